// File: rtl/alu_req_arbiter.sv
// Round-robin front end that time-shares one combinational ALU between two requesters and
// returns each captured result on a valid/ready response channel tagged with the requester id.
module alu_req_arbiter #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  output logic             rsp_dz,
  output logic             rsp_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] SEL_DIV  = 2'b11;
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             rr_q, rr_d;  // 1: req1 wins a tie
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_sel_q, alu_sel_d;
  logic             op_id_q, op_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_dz_q, rsp_dz_d;
  logic             rsp_id_q, rsp_id_d;

  logic grant0, grant1, dz;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      grant0 = req0_valid && (!req1_valid || !rr_q);
      grant1 = req1_valid && (!req0_valid || rr_q);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign dz = (alu_sel_q == SEL_DIV) && (alu_b_q == '0);

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch can leave a latch behind.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_dz_d    = rsp_dz_q;
    rsp_id_d    = rsp_id_q;

    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          alu_a_d   = grant1 ? req1_a : req0_a;
          alu_b_d   = grant1 ? req1_b : req0_b;
          alu_sel_d = grant1 ? req1_sel : req0_sel;
          op_id_d   = grant1;
          rr_d      = !grant1;  // next tie goes to whoever was not just served
          cnt_d     = CNT_LOAD;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_id_d = op_id_q;
          rsp_dz_d = dz;
          if (dz) begin
            rsp_data_d = '1;
            rsp_ovf_d  = 1'b1;
          end else begin
            rsp_data_d = alu_out;
            // The ALU's flag carries no meaning for a legal divide.
            rsp_ovf_d  = (alu_sel_q == SEL_DIV) ? 1'b0 : alu_ovf;
          end
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rr_q        <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= 2'b00;
      op_id_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_dz_q    <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_dz_q    <= rsp_dz_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_dz    = rsp_dz_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a transaction-level model checked every cycle against the
// SETTLE=2 instance, directed literal checks for each scenario, and a SETTLE=1 instance.
module tb_alu_req_arbiter;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_sel, req1_sel;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [1:0]  alu_sel;
  logic        alu_ovf;
  logic        rsp_valid, rsp_ready, rsp_ovf, rsp_dz, rsp_id;
  logic [15:0] rsp_data;

  logic        s1_req0_valid, s1_req0_ready, s1_req1_ready;
  logic [15:0] s1_req0_a, s1_req0_b;
  logic [1:0]  s1_req0_sel;
  logic [15:0] s1_alu_a, s1_alu_b, s1_alu_out;
  logic [1:0]  s1_alu_sel;
  logic        s1_alu_ovf;
  logic        s1_rsp_valid, s1_rsp_ready, s1_rsp_ovf, s1_rsp_dz, s1_rsp_id;
  logic [15:0] s1_rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Stand-in ALU: deliberately garbage output on divide-by-zero and a set flag on legal divides.
  function automatic logic [16:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [1:0] sel);
    logic [31:0] p;
    case (sel)
      2'b00: alu_fn = {1'b0, a} + {1'b0, b};
      2'b01: alu_fn = {b > a, a - b};
      2'b10: begin p = a * b; alu_fn = {|p[31:16], p[15:0]}; end
      default: alu_fn = (b == 16'd0) ? {1'b0, 16'h1234} : {1'b1, a / b};
    endcase
  endfunction

  assign {alu_ovf, alu_out}       = alu_fn(alu_a, alu_b, alu_sel);
  assign {s1_alu_ovf, s1_alu_out} = alu_fn(s1_alu_a, s1_alu_b, s1_alu_sel);

  // Expected response {dz, ovf, data} from the arithmetic meaning of each op.
  function automatic logic [17:0] spec_rsp(input logic [15:0] a, input logic [15:0] b, input logic [1:0] sel);
    int unsigned ua, ub, r;
    ua = a;
    ub = b;
    case (sel)
      2'b00: begin r = ua + ub; spec_rsp = {1'b0, r > 65535, 16'(r & 32'hFFFF)}; end
      2'b01: begin r = ua - ub; spec_rsp = {1'b0, ua < ub, 16'(r & 32'hFFFF)}; end
      2'b10: begin r = ua * ub; spec_rsp = {1'b0, r > 65535, 16'(r & 32'hFFFF)}; end
      default: begin
        if (ub == 0) spec_rsp = {1'b1, 1'b1, 16'hFFFF};
        else         spec_rsp = {1'b0, 1'b0, 16'(ua / ub)};
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  alu_req_arbiter #(.WIDTH(16), .SETTLE(S)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_ovf(rsp_ovf), .rsp_dz(rsp_dz), .rsp_id(rsp_id)
  );

  alu_req_arbiter #(.WIDTH(16), .SETTLE(1)) dut_s1 (
    .clk(clk), .rst(rst),
    .req0_valid(s1_req0_valid), .req0_ready(s1_req0_ready), .req0_a(s1_req0_a), .req0_b(s1_req0_b),
    .req0_sel(s1_req0_sel),
    .req1_valid(1'b0), .req1_ready(s1_req1_ready), .req1_a(16'h0000), .req1_b(16'h0000), .req1_sel(2'b00),
    .alu_a(s1_alu_a), .alu_b(s1_alu_b), .alu_sel(s1_alu_sel), .alu_out(s1_alu_out), .alu_ovf(s1_alu_ovf),
    .rsp_valid(s1_rsp_valid), .rsp_ready(s1_rsp_ready), .rsp_data(s1_rsp_data),
    .rsp_ovf(s1_rsp_ovf), .rsp_dz(s1_rsp_dz), .rsp_id(s1_rsp_id)
  );

  // Transaction model: busy from grant until handshake; response visible S edges after grant.
  bit          m_live = 1'b0;
  bit          m_busy, m_last, m_pend_id, m_rid, m_gid;
  int          m_age;
  logic [15:0] m_a, m_b, m_rdata;
  logic [1:0]  m_sel;
  logic [17:0] m_pend;
  logic        m_rovf, m_rdz;

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1'b1; m_busy = 1'b0; m_age = 0; m_last = 1'b1;
      m_a = '0; m_b = '0; m_sel = '0;
      m_rdata = '0; m_rovf = 1'b0; m_rdz = 1'b0; m_rid = 1'b0;
    end else if (m_live) begin
      if (m_busy) begin
        if (m_age >= S && rsp_ready) begin
          m_busy = 1'b0;
        end else if (m_age < S) begin
          m_age++;
          if (m_age == S) begin
            {m_rdz, m_rovf, m_rdata} = m_pend;
            m_rid = m_pend_id;
          end
        end
      end else if (req0_valid || req1_valid) begin
        m_gid     = (req0_valid && req1_valid) ? !m_last : req1_valid;
        m_a       = m_gid ? req1_a : req0_a;
        m_b       = m_gid ? req1_b : req0_b;
        m_sel     = m_gid ? req1_sel : req0_sel;
        m_pend    = spec_rsp(m_a, m_b, m_sel);
        m_pend_id = m_gid;
        m_last    = m_gid;
        m_busy    = 1'b1;
        m_age     = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("ready", {req1_ready, req0_ready},
            {!m_busy && req1_valid && (!req0_valid || !m_last), !m_busy && req0_valid && (!req1_valid || m_last)});
      check("alu_ops", {alu_sel, alu_a, alu_b}, {m_sel, m_a, m_b});
      check("rsp_valid", rsp_valid, m_busy && m_age >= S);
      check("rsp_payload", {rsp_id, rsp_dz, rsp_ovf, rsp_data}, {m_rid, m_rdz, m_rovf, m_rdata});
    end
  end

  task automatic grant_op(input bit id, input logic [15:0] a, input logic [15:0] b, input logic [1:0] sel);
    int n;
    @(posedge clk); #1;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel; end
    n = 0;
    do begin @(negedge clk); n++; end while (!(id ? req1_ready : req0_ready) && n < 50);
    if (!(id ? req1_ready : req0_ready)) check("grant_timeout", 0, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 50);
    if (!rsp_valid) check("rsp_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int grants[$];
    int nrsp;

    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
    rsp_ready = 1'b1;
    s1_req0_valid = 0; s1_req0_a = 0; s1_req0_b = 0; s1_req0_sel = 0; s1_rsp_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {rsp_valid, rsp_data, rsp_ovf, rsp_dz, rsp_id, alu_a, alu_b, alu_sel}, 0);

    // 1: single add on req0
    grant_op(0, 16'h0003, 16'h0004, 2'b00);
    wait_rsp(lat);
    check("t1_latency", lat, 3);
    check("t1_rsp", {rsp_id, rsp_ovf, rsp_data}, {1'b0, 1'b0, 16'h0007});

    // 2: both requesters valid every cycle from a fresh reset
    pulse_reset();
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 16'h0100; req0_b = 16'h0100; req0_sel = 2'b10;
    req1_valid = 1; req1_a = 16'h0005; req1_b = 16'h0003; req1_sel = 2'b01;
    nrsp = 0;
    for (int c = 0; c < 60 && nrsp < 4; c++) begin
      @(negedge clk);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (rsp_valid) begin
        nrsp++;
        if (rsp_id) check("t2_rsp_req1", {rsp_ovf, rsp_data}, {1'b0, 16'h0002});
        else        check("t2_rsp_req0", {rsp_ovf, rsp_data}, {1'b1, 16'h0000});
      end
    end
    @(posedge clk); #1; req0_valid = 0; req1_valid = 0;
    check("t2_grant_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) check("t2_grant_order", grants[i], i % 2);

    // 3: divide by zero, then a legal divide
    grant_op(1, 16'h0064, 16'h0000, 2'b11);
    wait_rsp(lat);
    check("t3_div0", {rsp_id, rsp_dz, rsp_ovf, rsp_data}, {1'b1, 1'b1, 1'b1, 16'hFFFF});
    grant_op(1, 16'h0064, 16'h0007, 2'b11);
    wait_rsp(lat);
    check("t3_div", {rsp_id, rsp_dz, rsp_ovf, rsp_data}, {1'b1, 1'b0, 1'b0, 16'h000E});

    // 4: consumer stalls with req0 waiting
    @(posedge clk); #1; rsp_ready = 1'b0;
    grant_op(1, 16'h0010, 16'h0002, 2'b00);
    wait_rsp(lat);
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 16'h0009; req0_b = 16'h0001; req0_sel = 2'b01;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t4_hold_ready", req0_ready, 0);
      check("t4_hold_rsp", {rsp_valid, rsp_id, rsp_dz, rsp_ovf, rsp_data}, {1'b1, 1'b1, 1'b0, 1'b0, 16'h0012});
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_before_hs", {rsp_valid, req0_ready}, 2'b10);
    @(negedge clk);
    check("t4_after_hs", {rsp_valid, req0_ready}, 2'b01);
    @(posedge clk); #1; req0_valid = 0;
    wait_rsp(lat);
    check("t4_req0_rsp", {rsp_id, rsp_ovf, rsp_data}, {1'b0, 1'b0, 16'h0008});

    // 5: reset during EXEC abandons the op
    grant_op(1, 16'h0001, 16'h0001, 2'b00);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("t5_reset_outputs",
          {rsp_valid, rsp_data, rsp_ovf, rsp_dz, rsp_id, alu_a, alu_b, alu_sel, req0_ready, req1_ready}, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t5_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 16'h0002; req0_b = 16'h0002; req0_sel = 2'b00;
    req1_valid = 1; req1_a = 16'h0003; req1_b = 16'h0003; req1_sel = 2'b00;
    @(negedge clk);
    check("t5_req0_priority", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1; req0_valid = 0; req1_valid = 0;
    wait_rsp(lat);
    check("t5_rsp", {rsp_id, rsp_ovf, rsp_data}, {1'b0, 1'b0, 16'h0004});

    // 6: SETTLE=1 instance, wrapping add
    @(posedge clk); #1;
    s1_req0_valid = 1; s1_req0_a = 16'hFFFF; s1_req0_b = 16'h0001; s1_req0_sel = 2'b00;
    @(negedge clk);
    check("t6_ready", s1_req0_ready, 1);
    @(posedge clk); #1; s1_req0_valid = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!s1_rsp_valid && lat < 50);
    check("t6_latency", lat, 2);
    check("t6_rsp", {s1_rsp_id, s1_rsp_dz, s1_rsp_ovf, s1_rsp_data}, {1'b0, 1'b0, 1'b1, 16'h0000});

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
